// File: rtl/code_prefetch.sv
// code_prefetch
//   Instruction prefetch queue for the x86 decoder. Fetches aligned 32-bit
//   dwords from the memory port and keeps up to 16 code bytes. It presents
//   them as a byte-0-aligned 128-bit window. The decoder removes whole
//   instructions by byte count. A flush restarts fetch at any byte address
//   and discards everything queued or in flight.
//
// Parameters
//   LATENCY     cycles from an accepted request to its data on i_data (1..4)
//   RESET_ADDR  linear address of the first code byte after reset
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   o_address/o_rd   dword fetch address / read request
//   i_grant          request accepted when o_rd & i_grant
//   i_data           read data, little-endian, LATENCY cycles after accept
//   i_flush/_addr    discard queue and in-flight reads, restart at byte addr
//   i_consume        bytes removed from queue head this cycle
//   o_codebuf        queue bytes, byte k at [8k+7:8k], zero at/above o_count
//   o_count          valid bytes (0..16)
//   o_ip             linear address of o_codebuf byte 0
//   o_err            one-cycle pulse when i_consume exceeded o_count
module code_prefetch #(
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] RESET_ADDR = 32'h000F_FFF0
) (
  input  logic         clock,
  input  logic         reset,
  output logic [31:0]  o_address,
  output logic         o_rd,
  input  logic         i_grant,
  input  logic [31:0]  i_data,
  input  logic         i_flush,
  input  logic [31:0]  i_flush_addr,
  input  logic [3:0]   i_consume,
  output logic [127:0] o_codebuf,
  output logic [4:0]   o_count,
  output logic [31:0]  o_ip,
  output logic         o_err
);

  // Queue and architectural state
  logic [127:0]        r_q;
  logic [4:0]          r_count;
  logic [31:0]         r_ip;
  logic [31:0]         r_fa;
  logic [1:0]          r_skip;
  logic [2:0]          r_inf;
  logic                r_epoch;
  logic                r_err;

  // Response tracking: one valid/epoch pair per cycle of read latency.
  logic [LATENCY-1:0]  r_sv;
  logic [LATENCY-1:0]  r_stag;

  logic [6:0]          w_need;
  logic                w_rd;
  logic                w_acc;
  logic                w_tail_v;
  logic                w_app_en;
  logic                w_over;
  logic [3:0]          w_cons;
  logic [4:0]          w_base;
  logic [2:0]          w_app_n;
  logic [31:0]         w_appd;
  logic [127:0]        w_shift;
  logic [127:0]        w_qn;
  logic [4:0]          w_count_n;
  logic [2:0]          w_inf_n;

  // Issue only when the queue has room for every outstanding dword plus
  // this one, counting against registered o_count (same-cycle consume is
  // not credited). Nothing is issued during reset or a flush cycle.
  assign w_need   = {2'b00, r_count} + {2'b00, r_inf + 3'd1, 2'b00};
  assign w_rd     = ~reset & ~i_flush & (w_need <= 7'd16);
  assign w_acc    = w_rd & i_grant;

  // Tail of the tracking shift register lines up with data on i_data.
  assign w_tail_v = r_sv[LATENCY-1];
  assign w_app_en = w_tail_v & (r_stag[LATENCY-1] == r_epoch);

  // An over-long consume is rejected outright; the queue does not shift.
  assign w_over   = {1'b0, i_consume} > r_count;
  assign w_cons   = w_over ? 4'd0 : i_consume;
  assign w_base   = r_count - {1'b0, w_cons};

  // Only the first response after a flush can carry a non-zero skip.
  assign w_app_n  = 3'd4 - {1'b0, r_skip};
  assign w_appd   = i_data >> {r_skip, 3'b000};
  assign w_shift  = r_q >> {w_cons, 3'b000};

  // Shift first, then drop the appended bytes in at the post-shift tail.
  always_comb begin
    w_qn = w_shift;
    for (int unsigned k = 0; k < 16; k++) begin
      if (w_app_en && (k >= 32'(w_base)) && (k < 32'(w_base) + 32'(w_app_n))) begin
        w_qn[k*8 +: 8] = w_appd[8*(k - 32'(w_base)) +: 8];
      end
    end
  end

  assign w_count_n = w_base + (w_app_en ? {2'b00, w_app_n} : 5'd0);

  // Stale responses still retire their in-flight slot.
  assign w_inf_n   = r_inf + {2'b00, w_acc} - {2'b00, w_tail_v};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q     <= '0;
      r_count <= '0;
      r_ip    <= RESET_ADDR;
      r_fa    <= {RESET_ADDR[31:2], 2'b00};
      r_skip  <= RESET_ADDR[1:0];
      r_inf   <= '0;
      r_epoch <= 1'b0;
      r_err   <= 1'b0;
      r_sv    <= '0;
      r_stag  <= '0;
    end else begin
      r_sv[0]   <= w_acc;
      r_stag[0] <= r_epoch;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_sv[i]   <= r_sv[i-1];
        r_stag[i] <= r_stag[i-1];
      end
      r_inf <= w_inf_n;

      if (i_flush) begin
        // Toggling the epoch turns every read still in flight into a
        // stale response; the one landing this cycle is dropped too.
        r_q     <= '0;
        r_count <= '0;
        r_ip    <= i_flush_addr;
        r_fa    <= {i_flush_addr[31:2], 2'b00};
        r_skip  <= i_flush_addr[1:0];
        r_epoch <= ~r_epoch;
        r_err   <= 1'b0;
      end else begin
        r_q     <= w_qn;
        r_count <= w_count_n;
        r_ip    <= r_ip + 32'(w_cons);
        r_err   <= w_over;
        if (w_acc) begin
          r_fa <= r_fa + 32'd4;
        end
        if (w_app_en) begin
          r_skip <= 2'd0;
        end
      end
    end
  end

  assign o_address = r_fa;
  assign o_rd      = w_rd;
  assign o_codebuf = r_q;
  assign o_count   = r_count;
  assign o_ip      = r_ip;
  assign o_err     = r_err;

endmodule

// File: tb/tb_code_prefetch.sv
module tb_code_prefetch;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] RADDR = 32'h000F_FFF0;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  o_address;
  logic         o_rd;
  logic         i_grant;
  logic [31:0]  i_data;
  logic         i_flush;
  logic [31:0]  i_flush_addr;
  logic [3:0]   i_consume;
  logic [127:0] o_codebuf;
  logic [4:0]   o_count;
  logic [31:0]  o_ip;
  logic         o_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  code_prefetch #(.LATENCY(LAT), .RESET_ADDR(RADDR)) dut (
    .clock(clock), .reset(reset),
    .o_address(o_address), .o_rd(o_rd), .i_grant(i_grant), .i_data(i_data),
    .i_flush(i_flush), .i_flush_addr(i_flush_addr), .i_consume(i_consume),
    .o_codebuf(o_codebuf), .o_count(o_count), .o_ip(o_ip), .o_err(o_err)
  );

  // Memory contents: fixed words from the directed tests, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000F_FFF0: return 32'h2667_6601;
      32'h0000_1000: return 32'h4433_2211;
      32'h0000_1004: return 32'h8877_6655;
      default:       return {a[9:2] ^ 8'hC3, a[9:2] + 8'h5D, ~a[17:10], a[9:2] + a[25:18]};
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    w = w >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  function automatic logic [127:0] window(input logic [31:0] ip, input logic [4:0] cnt);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      if (k < int'(cnt)) r[k*8 +: 8] = byte_at(ip + 32'(k));
    return r;
  endfunction

  // Bus model: returns the addressed dword LAT edges after acceptance.
  logic [LAT-1:0] pv;
  logic [31:0]    pa [LAT];
  always @(posedge clock) begin
    if (reset) pv <= '0;
    else       pv[0] <= o_rd & i_grant;
    pa[0] <= o_address;
    for (int i = 1; i < LAT; i++) begin
      if (!reset) pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign i_data = pv[LAT-1] ? mem_word(pa[LAT-1]) : 32'h0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [31:0] exp_ip;
  int unsigned c;
  int unsigned cmax;

  initial begin
    reset = 1'b1; i_grant = 1'b1; i_flush = 1'b0; i_flush_addr = '0; i_consume = '0;
    cyc(3);
    chk("rst_count",   128'(o_count),   128'd0);
    chk("rst_codebuf", o_codebuf,       128'd0);
    chk("rst_ip",      128'(o_ip),      128'h000F_FFF0);
    chk("rst_rd",      128'(o_rd),      128'd0);
    chk("rst_addr",    128'(o_address), 128'h000F_FFF0);
    chk("rst_err",     128'(o_err),     128'd0);

    // Fill from the reset vector with grant held.
    reset = 1'b0;
    #1 chk("rd_after_reset", 128'(o_rd), 128'd1);
    cyc(1); chk("fill_n1_count", 128'(o_count), 128'd0);
    cyc(1); chk("fill_n2_count", 128'(o_count), 128'd0);
    cyc(1); chk("fill_n3_count", 128'(o_count), 128'd4);
    chk("fill_n3_dw0", 128'(o_codebuf[31:0]), 128'h2667_6601);
    chk("fill_n3_rd",  128'(o_rd), 128'd1);
    cyc(1); chk("fill_n4_count", 128'(o_count), 128'd8);
    chk("fill_n4_rd",  128'(o_rd), 128'd0);
    cyc(1); chk("fill_n5_count", 128'(o_count), 128'd12);
    cyc(1); chk("fill_n6_count", 128'(o_count), 128'd16);
    chk("fill_n6_rd",  128'(o_rd), 128'd0);
    chk("fill_n6_buf", o_codebuf, window(32'h000F_FFF0, 5'd16));
    cyc(3); chk("full_hold_count", 128'(o_count), 128'd16);
    chk("full_hold_rd", 128'(o_rd), 128'd0);

    // Misaligned flush to 0x1001.
    i_flush = 1'b1; i_flush_addr = 32'h0000_1001;
    #1 chk("flush_rd", 128'(o_rd), 128'd0);
    @(negedge clock); i_flush = 1'b0;
    chk("mis_n0_count", 128'(o_count), 128'd0);
    chk("mis_n0_ip",    128'(o_ip),    128'h1001);
    cyc(2); chk("mis_n2_count", 128'(o_count), 128'd0);
    cyc(1); chk("mis_n3_count", 128'(o_count), 128'd3);
    chk("mis_n3_buf", o_codebuf, 128'h44_3322);
    chk("mis_n3_ip",  128'(o_ip), 128'h1001);
    cyc(1); chk("mis_n4_count", 128'(o_count), 128'd7);
    chk("mis_n4_buf", o_codebuf, 128'h88_7766_5544_3322);
    chk("mis_n4_ip",  128'(o_ip), 128'h1001);
    cyc(2); chk("mis_n6_count", 128'(o_count), 128'd15);
    chk("mis_n6_rd",  128'(o_rd), 128'd0);

    // Aligned refill to 16, then consume 3 per cycle.
    i_flush = 1'b1; i_flush_addr = 32'h0000_2000;
    @(negedge clock); i_flush = 1'b0;
    cyc(6); chk("al_count", 128'(o_count), 128'd16);
    exp_ip = 32'h0000_2000;
    for (int i = 0; i < 6; i++) begin
      i_consume = 4'd3;
      @(negedge clock);
      exp_ip = exp_ip + 32'd3;
      chk("c3_ip",  128'(o_ip), 128'(exp_ip));
      chk("c3_buf", o_codebuf, window(exp_ip, o_count));
      chk("c3_err", 128'(o_err), 128'd0);
    end

    // Random legal consumes with intermittent grant.
    for (int i = 0; i < 200; i++) begin
      cmax = (o_count > 5'd15) ? 15 : 32'(o_count);
      c = $urandom_range(cmax, 0);
      i_consume = 4'(c);
      i_grant = ($urandom_range(3, 0) != 0);
      @(negedge clock);
      exp_ip = exp_ip + 32'(c);
      chk("rnd_ip",  128'(o_ip), 128'(exp_ip));
      chk("rnd_buf", o_codebuf, window(exp_ip, o_count));
      chk("rnd_err", 128'(o_err), 128'd0);
    end
    i_consume = '0; i_grant = 1'b0;
    cyc(LAT + 2);

    // Flush with two reads in flight.
    i_flush = 1'b1; i_flush_addr = 32'h0000_3000;
    @(negedge clock); i_flush = 1'b0; i_grant = 1'b1;
    cyc(2);
    i_grant = 1'b0; i_flush = 1'b1; i_flush_addr = 32'h0000_5002;
    @(negedge clock); i_flush = 1'b0;
    chk("stale_n3_count", 128'(o_count), 128'd0);
    chk("stale_n3_ip",    128'(o_ip),    128'h5002);
    cyc(1);
    chk("stale_n4_count", 128'(o_count), 128'd0);
    chk("stale_n4_buf",   o_codebuf,     128'd0);
    chk("stale_n4_addr",  128'(o_address), 128'h5000);
    i_grant = 1'b1;
    cyc(2); chk("stale_n6_count", 128'(o_count), 128'd0);
    cyc(1); chk("stale_n7_count", 128'(o_count), 128'd2);
    chk("stale_n7_buf", o_codebuf, window(32'h0000_5002, 5'd2));
    chk("stale_n7_ip",  128'(o_ip), 128'h5002);
    i_grant = 1'b0;
    cyc(4);

    // Over-long consume.
    i_flush = 1'b1; i_flush_addr = 32'h0000_1000;
    @(negedge clock); i_flush = 1'b0; i_grant = 1'b1;
    @(negedge clock); i_grant = 1'b0;
    cyc(2); chk("err_pre_count", 128'(o_count), 128'd4);
    i_consume = 4'd5;
    @(negedge clock); i_consume = 4'd0;
    chk("err_pulse", 128'(o_err),   128'd1);
    chk("err_count", 128'(o_count), 128'd4);
    chk("err_ip",    128'(o_ip),    128'h1000);
    @(negedge clock);
    chk("err_clear",  128'(o_err),   128'd0);
    chk("err_count2", 128'(o_count), 128'd4);

    // Same-cycle append and consume.
    i_flush = 1'b1; i_flush_addr = 32'h0000_1002;
    @(negedge clock); i_flush = 1'b0; i_grant = 1'b1;
    cyc(3); i_grant = 1'b0;
    chk("ac_n3_count", 128'(o_count), 128'd2);
    cyc(1); chk("ac_n4_count", 128'(o_count), 128'd6);
    i_consume = 4'd2;
    @(negedge clock); i_consume = 4'd0;
    chk("ac_n5_count", 128'(o_count), 128'd8);
    chk("ac_n5_ip",    128'(o_ip),    128'h1004);
    chk("ac_n5_buf",   o_codebuf, {64'h0, mem_word(32'h0000_1008), 32'h8877_6655});

    // Address wrap.
    i_grant = 1'b1; i_flush = 1'b1; i_flush_addr = 32'hFFFF_FFFE;
    @(negedge clock); i_flush = 1'b0;
    cyc(2); chk("wrap_addr", 128'(o_address), 128'h4);
    cyc(1); chk("wrap_n3_count", 128'(o_count), 128'd2);
    chk("wrap_n3_buf", o_codebuf, window(32'hFFFF_FFFE, 5'd2));
    cyc(1); chk("wrap_n4_count", 128'(o_count), 128'd6);
    chk("wrap_n4_buf", o_codebuf, window(32'hFFFF_FFFE, 5'd6));
    chk("wrap_n4_ip",  128'(o_ip), 128'hFFFF_FFFE);

    // Reset mid-operation with reads in flight.
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("mrst_count", 128'(o_count), 128'd0);
    chk("mrst_ip",    128'(o_ip),    128'h000F_FFF0);
    chk("mrst_buf",   o_codebuf,     128'd0);
    cyc(2); chk("mrst_n2_count", 128'(o_count), 128'd0);
    cyc(1); chk("mrst_n3_count", 128'(o_count), 128'd4);
    chk("mrst_n3_dw0", 128'(o_codebuf[31:0]), 128'h2667_6601);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/code_prefetch.md
# code_prefetch

Instruction prefetch queue feeding the x86 decoder. Fetches aligned 32-bit dwords from the memory port and holds up to 16 code bytes. It presents them as a byte-0-aligned 128-bit window for the decoder's code buffer input. The decoder consumes whole instructions by byte count. A flush (jump, interrupt, reset vector) restarts fetch at any byte address, discarding in-flight data.

## Interface

Parameters:
- LATENCY, 2: cycles from an accepted read request to its data on i_data; legal range 1..4.
- RESET_ADDR, 32'h000F_FFF0: linear address of the first code byte after reset.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- o_address  out  32  dword fetch address; bits [1:0] always 0.
- o_rd  out  1  read request this cycle.
- i_grant  in  1  bus granted to fetch; a request is accepted only when o_rd & i_grant.
- i_data  in  32  read data, little-endian; byte 0 = bits [7:0].
- i_flush  in  1  discard queue and in-flight reads, restart at i_flush_addr.
- i_flush_addr  in  32  new code byte address.
- i_consume  in  4  bytes removed from queue head this cycle; 0 = none.
- o_codebuf  out  128  queue bytes; byte k at bits [8k+7:8k]; bytes at and above o_count are 0.
- o_count  out  5  valid bytes, 0..16.
- o_ip  out  32  linear address of o_codebuf byte 0.
- o_err  out  1  one-cycle pulse: i_consume exceeded o_count.

## Operation

- State: 16-byte queue, o_count, o_ip, fetch pointer fa (dword-aligned), skip (0..3 bytes to drop from the next returned dword), in-flight counter inf (0..LATENCY), LATENCY-deep valid/epoch shift register, 1-bit epoch.
- Issue rule: o_rd = 1 when o_count + 4*(inf+1) <= 16 and not in reset. Registered o_count is used; a same-cycle consume is not credited. When accepted: fa += 4, inf += 1, shift-register tag = current epoch.
- Response: when the shift-register tail is valid and the tag equals epoch, the dword is appended at the queue tail, minus its low skip bytes. The byte count appended is 4 - skip. skip then becomes 0 and inf -= 1. Stale-tag responses are dropped, but inf is still decremented.
- Consume: if i_consume <= o_count, the queue shifts down by i_consume bytes, o_ip += i_consume and o_count -= i_consume. Otherwise there is no shift, o_err pulses and state is otherwise unchanged.
- Same-cycle consume and append: the shift is applied first, then the append at the new tail. New o_count = o_count - i_consume + appended.
- Flush, which has priority over consume, append and issue in its cycle:
  - o_count = 0, o_ip = i_flush_addr, fa = {i_flush_addr[31:2], 2'b00}, skip = i_flush_addr[1:0], epoch toggles.
  - No request is issued in the flush cycle.
  - Any response landing in the flush cycle is dropped.
- Address arithmetic is modulo 2^32; fa and o_ip wrap from 0xFFFF_FFFC/0xFFFF_FFFF to 0 with no special handling.

## Timing

- Reset values:
  - o_count = 0, o_codebuf = 0, o_ip = RESET_ADDR, o_rd = 0, o_address = RESET_ADDR & ~3, o_err = 0.
  - inf = 0, skip = RESET_ADDR[1:0], epoch = 0, shift register cleared.
- First request: the first cycle after reset deasserts.
- Request accepted at edge t: data is sampled at edge t+LATENCY and is visible on o_codebuf/o_count after that edge, i.e. it is usable by the decoder in cycle t+LATENCY+1.
- Sustained fetch with i_grant = 1 and no consume: one request per cycle until the issue rule blocks.
- Consume takes effect on the next edge. o_codebuf, o_count and o_ip are registered, with no combinational path from inputs.
- Reset asserted mid-operation wins over everything, and all in-flight responses are discarded.

## Test plan

- Reset with RESET_ADDR = 0xFFFF0, mem[0xFFFF0] = 0x26676601, LATENCY = 2, grant held:
  - o_rd rises the cycle after reset.
  - After the first response, o_count = 4 and o_codebuf[31:0] = 0x26676601.
  - o_count reaches 16 and stops; o_rd stays 0 at 16.
- Misaligned flush to 0x1001, with mem[0x1000] = 0x44332211 and mem[0x1004] = 0x88776655:
  - First response gives o_count = 3 and bytes 22,33,44.
  - Next response gives 7 bytes: 22..88 in order.
  - o_ip = 0x1001 throughout.
- Flush while 2 reads are in flight:
  - Both stale responses are dropped; o_count stays 0 until new-epoch data arrives.
  - o_ip equals the flush address.
- With o_count = 16, consume 3 each cycle:
  - o_ip advances by 3 per cycle.
  - Fetch resumes and queue bytes stay in correct order versus a memory byte model over 200 random consumes (0..15, never exceeding o_count).
- Consume 5 with o_count = 4: o_err pulses for 1 cycle; o_count and o_ip are unchanged.
- Same-cycle append of a dword and consume 2 with o_count = 6: next o_count = 8, and the new dword occupies bytes 4..7.
